// File: rtl/apb2axi_cpl_arbiter.sv
// Merges read and write completions into the single completion FIFO push port.
// Optional statistics counters are built when APB2AXI_CPL_STATS_EN is defined.
// Payload is opaque, except that the MSB (completion_entry_t.is_write) steers the stats counters.
module apb2axi_cpl_arbiter #(
    parameter int COMPLETION_W = 32,
    parameter int SRC_DEPTH    = 4
`ifdef APB2AXI_CPL_STATS_EN
   ,parameter int CNT_W        = 16
`endif
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          rd_cpl_valid,
    input  logic [COMPLETION_W-1:0]       rd_cpl_data,
    output logic                          rd_cpl_ready,
    input  logic                          wr_cpl_valid,
    input  logic [COMPLETION_W-1:0]       wr_cpl_data,
    output logic                          wr_cpl_ready,
    output logic                          cpl_push_valid,
    output logic [COMPLETION_W-1:0]       cpl_push_data,
    input  logic                          cpl_push_ready,
    output logic [$clog2(SRC_DEPTH):0]    rd_q_level,
    output logic [$clog2(SRC_DEPTH):0]    wr_q_level
`ifdef APB2AXI_CPL_STATS_EN
   ,output logic [CNT_W-1:0]              stat_rd_cnt,
    output logic [CNT_W-1:0]              stat_wr_cnt,
    output logic [CNT_W-1:0]              stat_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(SRC_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RD    = 0;
    localparam int WR    = 1;

    typedef enum logic {S_EMPTY, S_HOLD} out_state_t;
    typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

    logic [1:0]                   push_p0;
    logic [1:0]                   pop_p0;
    logic [1:0]                   not_full_p0;
    logic [1:0]                   not_empty_p0;
    logic [1:0][COMPLETION_W-1:0] in_data_p0;
    logic [1:0][COMPLETION_W-1:0] head_p0;
    logic [1:0][LVL_W-1:0]        level_p0;

    out_state_t                   state_p1;
    out_state_t                   state_nxt;
    logic [COMPLETION_W-1:0]      data_p1;
    grant_t                       last_grant;
    logic                         load;
    logic                         grant_rd;

    assign in_data_p0[RD] = rd_cpl_data;
    assign in_data_p0[WR] = wr_cpl_data;
    assign push_p0        = {wr_cpl_valid & not_full_p0[WR], rd_cpl_valid & not_full_p0[RD]};

    // ---- Stage p0: per-source completion queues ----
    for (genvar s = 0; s < 2; s++) begin : g_q
        logic [COMPLETION_W-1:0] mem [SRC_DEPTH];
        logic [PTR_W-1:0]        wptr;
        logic [PTR_W-1:0]        rptr;
        logic [LVL_W-1:0]        lvl;

        // Ready depends on the occupancy alone, never on a same-cycle pop.
        assign not_full_p0[s]  = (lvl != LVL_W'(SRC_DEPTH));
        assign not_empty_p0[s] = (lvl != '0);
        assign head_p0[s]      = mem[rptr];
        assign level_p0[s]     = lvl;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                wptr <= '0;
                rptr <= '0;
                lvl  <= '0;
            end else begin
                if (push_p0[s]) wptr <= wptr + PTR_W'(1);
                if (pop_p0[s])  rptr <= rptr + PTR_W'(1);
                case ({push_p0[s], pop_p0[s]})
                    2'b10:   lvl <= lvl + LVL_W'(1);
                    2'b01:   lvl <= lvl - LVL_W'(1);
                    default: lvl <= lvl;
                endcase
            end
        end

        always_ff @(posedge aclk) begin
            if (push_p0[s]) mem[wptr] <= in_data_p0[s];
        end
    end

    assign rd_cpl_ready = not_full_p0[RD];
    assign wr_cpl_ready = not_full_p0[WR];
    assign rd_q_level   = level_p0[RD];
    assign wr_q_level   = level_p0[WR];

    // ---- Stage p1: round-robin arbitration and registered output ----
    always_comb begin
        state_nxt = state_p1;
        load      = ((state_p1 == S_EMPTY) || cpl_push_ready) && (|not_empty_p0);
        grant_rd  = not_empty_p0[RD] && (!not_empty_p0[WR] || (last_grant == GRANT_WR));
        pop_p0    = {load && !grant_rd, load && grant_rd};
        case (state_p1)
            S_EMPTY: if (load) state_nxt = S_HOLD;
            S_HOLD:  if (cpl_push_ready && !load) state_nxt = S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_p1   <= S_EMPTY;
            data_p1    <= '0;
            last_grant <= GRANT_WR;
        end else begin
            state_p1 <= state_nxt;
            if (load) begin
                data_p1    <= grant_rd ? head_p0[RD] : head_p0[WR];
                last_grant <= grant_rd ? GRANT_RD : GRANT_WR;
            end
        end
    end

    assign cpl_push_valid = (state_p1 == S_HOLD);
    assign cpl_push_data  = data_p1;

`ifdef APB2AXI_CPL_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic delivered;
    logic is_write;

    assign delivered = cpl_push_valid && cpl_push_ready;
    assign is_write  = data_p1[COMPLETION_W-1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (delivered && !is_write) stat_rd_cnt <= sat_inc(stat_rd_cnt);
            if (delivered && is_write)  stat_wr_cnt <= sat_inc(stat_wr_cnt);
            if (cpl_push_valid && !cpl_push_ready) stat_stall_cnt <= sat_inc(stat_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_apb2axi_cpl_arbiter.sv
// Directed bench for apb2axi_cpl_arbiter: vector table plus hand-written sequences.
// Stats checks are compiled in when APB2AXI_CPL_STATS_EN is defined.
module tb_apb2axi_cpl_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        rd_cpl_valid;
    logic [31:0] rd_cpl_data;
    logic        rd_cpl_ready;
    logic        wr_cpl_valid;
    logic [31:0] wr_cpl_data;
    logic        wr_cpl_ready;
    logic        cpl_push_valid;
    logic [31:0] cpl_push_data;
    logic        cpl_push_ready;
    logic [2:0]  rd_q_level;
    logic [2:0]  wr_q_level;

    int total = 0;
    int bad   = 0;

`ifdef APB2AXI_CPL_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
    logic        s_rd_rdy, s_wr_rdy, s_valid;
    logic [31:0] s_data;
    logic [2:0]  s_rl, s_wl;
    logic [3:0]  sat_rd_cnt, sat_wr_cnt, sat_stall_cnt;
`endif

    apb2axi_cpl_arbiter #(.COMPLETION_W(32), .SRC_DEPTH(4)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_cpl_valid(rd_cpl_valid), .rd_cpl_data(rd_cpl_data), .rd_cpl_ready(rd_cpl_ready),
        .wr_cpl_valid(wr_cpl_valid), .wr_cpl_data(wr_cpl_data), .wr_cpl_ready(wr_cpl_ready),
        .cpl_push_valid(cpl_push_valid), .cpl_push_data(cpl_push_data),
        .cpl_push_ready(cpl_push_ready),
        .rd_q_level(rd_q_level), .wr_q_level(wr_q_level)
`ifdef APB2AXI_CPL_STATS_EN
       ,.stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

`ifdef APB2AXI_CPL_STATS_EN
    apb2axi_cpl_arbiter #(.COMPLETION_W(32), .SRC_DEPTH(4), .CNT_W(4)) u_sat (
        .aclk(aclk), .aresetn(aresetn),
        .rd_cpl_valid(rd_cpl_valid), .rd_cpl_data(rd_cpl_data), .rd_cpl_ready(s_rd_rdy),
        .wr_cpl_valid(wr_cpl_valid), .wr_cpl_data(wr_cpl_data), .wr_cpl_ready(s_wr_rdy),
        .cpl_push_valid(s_valid), .cpl_push_data(s_data), .cpl_push_ready(cpl_push_ready),
        .rd_q_level(s_rl), .wr_q_level(s_wl),
        .stat_rd_cnt(sat_rd_cnt), .stat_wr_cnt(sat_wr_cnt), .stat_stall_cnt(sat_stall_cnt)
    );
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        rd_v;
        logic [31:0] rd_d;
        logic        wr_v;
        logic [31:0] wr_d;
        logic        rdy;
        logic        e_v;
        logic [31:0] e_d;
        logic [2:0]  e_rl;
        logic [2:0]  e_wl;
    } vec_t;

    vec_t vecs [12];

    // Payload: bit31 is_write, [7:4] num_beats, [3:0] tag.
    localparam logic [31:0] CPL_A = 32'h0000_0043;  // rd tag 3, 4 beats
    localparam logic [31:0] CPL_B = 32'h0000_0011;  // rd tag 1
    localparam logic [31:0] CPL_C = 32'h8000_0022;  // wr tag 2
    localparam logic [31:0] CPL_D = 32'h8000_0035;  // wr tag 5
    localparam logic [31:0] CPL_E = 32'h0000_0027;
    localparam logic [31:0] CPL_F = 32'h8000_0018;

    function automatic logic [31:0] rd_item(input int i);
        return 32'h0000_0100 + 32'(i);
    endfunction

    function automatic logic [31:0] wr_item(input int i);
        return 32'h8000_0200 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_cpl_valid = 1'b0;
        rd_cpl_data  = '0;
        wr_cpl_valid = 1'b0;
        wr_cpl_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        cpl_push_ready = 1'b1;
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        logic [31:0] got [$];
        logic [31:0] exp_q [$];
        int nr, nw, rd_bad;
        logic racc, wacc;

        vecs[0]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
        vecs[1]  = '{1'b1, CPL_B, 1'b1, CPL_C, 1'b1, 1'b0, 32'h0, 3'd1, 3'd1};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, CPL_B, 3'd0, 3'd1};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, CPL_C, 3'd0, 3'd0};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
        vecs[5]  = '{1'b1, CPL_A, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd1, 3'd0};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, CPL_A, 3'd0, 3'd0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, CPL_D, 1'b0, 1'b0, 32'h0, 3'd0, 3'd1};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, CPL_D, 3'd0, 3'd0};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, CPL_D, 3'd0, 3'd0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 3'd0};

        idle_inputs();
        cpl_push_ready = 1'b1;
        aresetn = 1'b0;
        tick();
        tick();
        check("reset valid", cpl_push_valid, 1'b0);
        check("reset data", cpl_push_data, 32'h0);
        check("reset rd_lvl", rd_q_level, 3'd0);
        check("reset wr_lvl", wr_q_level, 3'd0);
        check("reset rd_rdy", rd_cpl_ready, 1'b1);
        check("reset wr_rdy", wr_cpl_ready, 1'b1);
        aresetn = 1'b1;

        // Vector table: inputs held across one edge, outputs checked after it.
        for (int i = 0; i < 12; i++) begin
            rd_cpl_valid   = vecs[i].rd_v;
            rd_cpl_data    = vecs[i].rd_d;
            wr_cpl_valid   = vecs[i].wr_v;
            wr_cpl_data    = vecs[i].wr_d;
            cpl_push_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d valid", i), cpl_push_valid, vecs[i].e_v);
            if (vecs[i].e_v) check($sformatf("vec%0d data", i), cpl_push_data, vecs[i].e_d);
            check($sformatf("vec%0d rd_lvl", i), rd_q_level, vecs[i].e_rl);
            check($sformatf("vec%0d wr_lvl", i), wr_q_level, vecs[i].e_wl);
            check($sformatf("vec%0d rd_rdy", i), rd_cpl_ready, 1'b1);
        end
        idle_inputs();

        // Fill both queues under back-pressure, then release.
        do_reset();
        cpl_push_ready = 1'b0;
        nr = 0;
        nw = 0;
        for (int c = 0; c < 14; c++) begin
            rd_cpl_valid = rd_cpl_ready;
            rd_cpl_data  = rd_item(nr);
            wr_cpl_valid = wr_cpl_ready;
            wr_cpl_data  = wr_item(nw);
            racc = rd_cpl_valid && rd_cpl_ready;
            wacc = wr_cpl_valid && wr_cpl_ready;
            tick();
            if (racc) nr++;
            if (wacc) nw++;
        end
        idle_inputs();
        check("full rd accepted", 32'(nr), 32'd5);
        check("full wr accepted", 32'(nw), 32'd4);
        check("full rd_rdy", rd_cpl_ready, 1'b0);
        check("full wr_rdy", wr_cpl_ready, 1'b0);
        check("full rd_lvl", rd_q_level, 3'd4);
        check("full wr_lvl", wr_q_level, 3'd4);
        check("full valid", cpl_push_valid, 1'b1);
        check("full data", cpl_push_data, rd_item(0));
        for (int c = 0; c < 10; c++) tick();
        check("held valid", cpl_push_valid, 1'b1);
        check("held data", cpl_push_data, rd_item(0));
        check("held rd_lvl", rd_q_level, 3'd4);
        cpl_push_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 9; c++) begin
            if (cpl_push_valid) got.push_back(cpl_push_data);
            tick();
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rd_item(i));
            exp_q.push_back(wr_item(i));
        end
        exp_q.push_back(rd_item(4));
        check("drain count", 32'(got.size()), 32'd9);
        for (int i = 0; i < got.size() && i < 9; i++)
            check($sformatf("drain item%0d", i), got[i], exp_q[i]);
        check("drain empty valid", cpl_push_valid, 1'b0);

        // Continuous write stream with ready toggling every cycle.
        do_reset();
        got.delete();
        nw = 0;
        rd_bad = 0;
        for (int c = 0; c < 80 && got.size() < 12; c++) begin
            wr_cpl_valid   = (nw < 12) && wr_cpl_ready;
            wr_cpl_data    = wr_item(nw);
            cpl_push_ready = ((c % 2) == 1);
            if (cpl_push_valid && cpl_push_ready) got.push_back(cpl_push_data);
            if (!rd_cpl_ready) rd_bad++;
            wacc = wr_cpl_valid && wr_cpl_ready;
            tick();
            if (wacc) nw++;
        end
        idle_inputs();
        cpl_push_ready = 1'b1;
        tick();
        tick();
        check("stream count", 32'(got.size()), 32'd12);
        for (int i = 0; i < got.size() && i < 12; i++)
            check($sformatf("stream item%0d", i), got[i], wr_item(i));
        check("stream rd_rdy never low", 32'(rd_bad), 32'd0);
        check("stream no dup", cpl_push_valid, 1'b0);

        // Asynchronous reset while holding and with queued entries.
        do_reset();
        cpl_push_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rd_cpl_valid = 1'b1;
            rd_cpl_data  = rd_item(c);
            wr_cpl_valid = (c < 3);
            wr_cpl_data  = wr_item(c);
            tick();
        end
        idle_inputs();
        check("pre-rst valid", cpl_push_valid, 1'b1);
        check("pre-rst rd_lvl", rd_q_level, 3'd3);
        check("pre-rst wr_lvl", wr_q_level, 3'd3);
        #2;
        aresetn = 1'b0;
        #1;
        check("async rst valid", cpl_push_valid, 1'b0);
        check("async rst data", cpl_push_data, 32'h0);
        check("async rst rd_lvl", rd_q_level, 3'd0);
        check("async rst wr_lvl", wr_q_level, 3'd0);
        tick();
        aresetn = 1'b1;
        cpl_push_ready = 1'b1;
        rd_cpl_valid = 1'b1;
        rd_cpl_data  = CPL_E;
        wr_cpl_valid = 1'b1;
        wr_cpl_data  = CPL_F;
        tick();
        idle_inputs();
        check("post-rst lat1 valid", cpl_push_valid, 1'b0);
        tick();
        check("post-rst first valid", cpl_push_valid, 1'b1);
        check("post-rst first data", cpl_push_data, CPL_E);
        tick();
        check("post-rst second data", cpl_push_data, CPL_F);
        tick();
        check("post-rst idle", cpl_push_valid, 1'b0);

`ifdef APB2AXI_CPL_STATS_EN
        do_reset();
        cpl_push_ready = 1'b0;
        rd_cpl_valid = 1'b1;
        rd_cpl_data  = rd_item(0);
        tick();
        idle_inputs();
        tick();
        for (int c = 0; c < 7; c++) tick();
        cpl_push_ready = 1'b1;
        tick();
        for (int i = 1; i < 5; i++) begin
            rd_cpl_valid = 1'b1;
            rd_cpl_data  = rd_item(i);
            tick();
        end
        rd_cpl_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_cpl_valid = 1'b1;
            wr_cpl_data  = wr_item(i);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 5; c++) tick();
        check("stat_rd", stat_rd_cnt, 16'd5);
        check("stat_wr", stat_wr_cnt, 16'd3);
        check("stat_stall", stat_stall_cnt, 16'd7);
        check("sat4 stall pre", sat_stall_cnt, 4'd7);
        cpl_push_ready = 1'b0;
        wr_cpl_valid = 1'b1;
        wr_cpl_data  = wr_item(3);
        tick();
        idle_inputs();
        tick();
        for (int c = 0; c < 20; c++) tick();
        cpl_push_ready = 1'b1;
        tick();
        tick();
        check("stat_stall long", stat_stall_cnt, 16'd27);
        check("stat_wr long", stat_wr_cnt, 16'd4);
        check("sat4 stall", sat_stall_cnt, 4'd15);
        check("sat4 rd", sat_rd_cnt, 4'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
